seg_scan_display: RTL

//  Parametrised hex display controller; successor to the fixed six-digit combinational hex-to-7seg decode at system top.

---
 rtl/seg_scan_display.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: parametrised N-digit hex display controller.
// Drives static per-digit segment buses and a time-multiplexed segment/anode
// scan from one double-buffered value that commits only at frame boundaries.
// Optional feature macro: SEG_BLINK_EN (adds blink_mask port and blink phase).

// Per-digit hex decoder; gfedcba table is stored active-low, polarity applied on output.
module seg_digit_dec #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  logic [6:0] lowPat;

  // nibble -> active-low gfedcba pattern
  always_comb begin
    lowPat = 7'h7F;
    unique case (nib)
      4'h0: lowPat = 7'b1000000;
      4'h1: lowPat = 7'b1111001;
      4'h2: lowPat = 7'b0100100;
      4'h3: lowPat = 7'b0110000;
      4'h4: lowPat = 7'b0011001;
      4'h5: lowPat = 7'b0010010;
      4'h6: lowPat = 7'b0000010;
      4'h7: lowPat = 7'b1111000;
      4'h8: lowPat = 7'b0000000;
      4'h9: lowPat = 7'b0010000;
      4'hA: lowPat = 7'b0001000;
      4'hB: lowPat = 7'b0000011;
      4'hC: lowPat = 7'b1000110;
      4'hD: lowPat = 7'b0100001;
      4'hE: lowPat = 7'b0000110;
      4'hF: lowPat = 7'b0001110;
    endcase
  end

  assign seg = blank ? (ACTIVE_LOW ? 7'h7F : 7'h00)
                     : (ACTIVE_LOW ? lowPat : ~lowPat);
endmodule

module seg_scan_display #(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    pending,
  output logic [7*NUM_DIGITS-1:0] seg_all,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en
);
  localparam int N     = NUM_DIGITS;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);
  localparam bit   SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam bit   DIG_LOW = (DIG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [4*N-1:0]   dispVal, pendVal;
  logic [N-1:0]     dispDp, pendDp;
  logic             fb;

  assign fb = (cnt == CNT_MAX) && (idx == IDX_MAX);

  // refresh divider and scan digit index
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // double buffer: loads park in pend, commit at frame boundary; a load on fb bypasses
  always_ff @(posedge clk) begin
    if (!rst) begin
      dispVal <= '0;
      dispDp  <= '0;
      pendVal <= '0;
      pendDp  <= '0;
      pending <= 1'b0;
    end else if (load && fb) begin
      dispVal <= value;
      dispDp  <= dp_in;
      pending <= 1'b0;
    end else if (load) begin
      pendVal <= value;
      pendDp  <= dp_in;
      pending <= 1'b1;
    end else if (fb && pending) begin
      dispVal <= pendVal;
      dispDp  <= pendDp;
      pending <= 1'b0;
    end
  end

  logic [N-1:0] blinkOff;
`ifdef SEG_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_MAX = FR_W'(BLINK_FRAMES - 1);
  logic [FR_W-1:0] frameCnt;
  logic            phase;

  // frame counter; blink phase flips every BLINK_FRAMES frame boundaries
  always_ff @(posedge clk) begin
    if (!rst) begin
      frameCnt <= '0;
      phase    <= 1'b0;
    end else if (fb) begin
      if (frameCnt == FR_MAX) begin
        frameCnt <= '0;
        phase    <= ~phase;
      end else begin
        frameCnt <= frameCnt + FR_W'(1);
      end
    end
  end
  assign blinkOff = blink_mask & {N{phase}};
`else
  assign blinkOff = '0;
`endif

  logic [N-1:0] lzBlank, digBlank;
  logic         zeroRun;

  // leading-zero run from the leftmost digit down; digit 0 is never blanked
  always_comb begin
    zeroRun = 1'b1;
    lzBlank = '0;
    for (int k = N - 1; k >= 1; k--) begin
      zeroRun    = zeroRun & (dispVal[4*k +: 4] == 4'h0);
      lzBlank[k] = blank_lz & zeroRun;
    end
  end
  assign digBlank = lzBlank | blinkOff;

  logic [7*N-1:0] segAllNext;
  for (genvar g = 0; g < N; g++) begin : gDig
    seg_digit_dec #(.ACTIVE_LOW(SEG_LOW)) uDec (
      .nib  (dispVal[4*g +: 4]),
      .blank(digBlank[g]),
      .seg  (segAllNext[7*g +: 7])
    );
  end

  logic [3:0]   curNib;
  logic         curBlank, curDp, curDpOff;
  logic [N-1:0] oneHot;
  logic [6:0]   segScanNext;

  // select the scanned digit's nibble, dp and blanking
  always_comb begin
    curNib   = 4'h0;
    curBlank = 1'b0;
    curDp    = 1'b0;
    curDpOff = 1'b0;
    oneHot   = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        curNib    = dispVal[4*k +: 4];
        curBlank  = digBlank[k];
        curDp     = dispDp[k];
        curDpOff  = blinkOff[k];
        oneHot[k] = 1'b1;
      end
    end
  end

  seg_digit_dec #(.ACTIVE_LOW(SEG_LOW)) uScanDec (
    .nib  (curNib),
    .blank(curBlank),
    .seg  (segScanNext)
  );

  // registered display outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_all <= {N{SEG_OFF}};
      seg_out <= SEG_OFF;
      dp_out  <= SEG_LOW;
      dig_en  <= DIG_LOW ? '1 : '0;
    end else begin
      seg_all <= segAllNext;
      seg_out <= segScanNext;
      dp_out  <= SEG_LOW ? ~(curDp & ~curDpOff) : (curDp & ~curDpOff);
      dig_en  <= DIG_LOW ? ~oneHot : oneHot;
    end
  end
endmodule
